// File: rtl/fp32_adder.sv
// fp32_adder: single-precision (binary32) adder with a one-cycle registered result.
// Subnormal inputs and underflowing results are flushed to zero; no exception flags.
// Optional macro FP_ADD_RNE_EN selects round-to-nearest-even; without it the result
// is truncated (round toward zero).
module fp32_adder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] out,
    output logic        out_valid
);

    localparam logic [31:0] QNaN = 32'h7FC00000;

    // Unpacked operands
    logic        sa, sb;
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    logic [30:0] mag_a, mag_b;
    logic [23:0] ma, mb;

    // Ordered operands: l = larger magnitude, s = smaller
    logic        swap;
    logic        sl, ss;
    logic [7:0]  el, es;
    logic [23:0] ml, ms;

    // Alignment
    logic [7:0]  shift_dist;
    logic [49:0] shifted;
    logic [26:0] aligned;

    // Add / subtract and normalize
    logic [27:0]        sum_raw;
    logic [26:0]        diff_raw;
    logic [26:0]        norm;
    logic [4:0]         lz;
    logic signed [9:0]  exp_n;
    logic               is_cancel;

    // Rounding
    logic [23:0]        sig_n;
    logic               g_bit, r_bit, s_bit;
    logic               round_up;
    logic [24:0]        rounded;
    logic [22:0]        frac_r;
    logic signed [9:0]  exp_r;

    // Final result and output registers
    logic [31:0] result;
    logic [31:0] out_q, out_d;
    logic        valid_q, valid_d;

    // Unpack fields and classify; exp=0 is treated as zero (flush-to-zero)
    always_comb begin
        sa     = a[31];
        sb     = b[31];
        ea     = a[30:23];
        eb     = b[30:23];
        fa     = a[22:0];
        fb     = b[22:0];
        nan_a  = (ea == 8'hFF) && (fa != 23'd0);
        nan_b  = (eb == 8'hFF) && (fb != 23'd0);
        inf_a  = (ea == 8'hFF) && (fa == 23'd0);
        inf_b  = (eb == 8'hFF) && (fb == 23'd0);
        zero_a = (ea == 8'd0);
        zero_b = (eb == 8'd0);
        mag_a  = zero_a ? 31'd0 : a[30:0];
        mag_b  = zero_b ? 31'd0 : b[30:0];
        ma     = zero_a ? 24'd0 : {1'b1, fa};
        mb     = zero_b ? 24'd0 : {1'b1, fb};
    end

    // Order operands so the larger magnitude comes first
    always_comb begin
        swap = (mag_b > mag_a);
        if (swap) begin
            sl = sb;  el = eb;  ml = mb;
            ss = sa;  es = ea;  ms = ma;
        end else begin
            sl = sa;  el = ea;  ml = ma;
            ss = sb;  es = eb;  ms = mb;
        end
    end

    // Align the smaller significand into a 27-bit {sig, guard, round, sticky} word
    always_comb begin
        shift_dist = el - es;
        shifted    = 50'd0;
        aligned    = 27'd0;
        if (shift_dist >= 8'd26) begin
            aligned = {26'd0, |ms};
        end else begin
            // 26 zero bits below the significand, so a shift of <=25 loses nothing
            shifted = {ms, 26'd0} >> shift_dist;
            aligned = {shifted[49:24], |shifted[23:0]};
        end
    end

    // Effective add or subtract, then normalize the magnitude
    always_comb begin
        sum_raw   = {1'b0, ml, 3'b000} + {1'b0, aligned};
        diff_raw  = {ml, 3'b000} - aligned;
        lz        = 5'd0;
        // Last match wins, so lz ends up counting zeros above the highest set bit
        for (int i = 0; i < 27; i++) begin
            if (diff_raw[i]) lz = 5'(26 - i);
        end
        is_cancel = 1'b0;
        norm      = 27'd0;
        exp_n     = 10'sd0;
        if (sl == ss) begin
            if (sum_raw[27]) begin
                norm  = {sum_raw[27:2], sum_raw[1] | sum_raw[0]};
                exp_n = $signed({2'b00, el}) + 10'sd1;
            end else begin
                norm  = sum_raw[26:0];
                exp_n = $signed({2'b00, el});
            end
        end else begin
            is_cancel = (diff_raw == 27'd0);
            norm      = diff_raw << lz;
            exp_n     = $signed({2'b00, el}) - $signed({5'd0, lz});
        end
    end

    // Round the normalized significand; an overflow renormalizes to 1.0 x 2^(e+1)
    always_comb begin
        sig_n = norm[26:3];
        g_bit = norm[2];
        r_bit = norm[1];
        s_bit = norm[0];
`ifdef FP_ADD_RNE_EN
        round_up = g_bit & (r_bit | s_bit | sig_n[0]);
`else
        round_up = 1'b0;
`endif
        rounded = {1'b0, sig_n} + {24'd0, round_up};
        if (rounded[24]) begin
            frac_r = rounded[23:1];
            exp_r  = exp_n + 10'sd1;
        end else begin
            frac_r = rounded[22:0];
            exp_r  = exp_n;
        end
    end

    // Special-case selection and final packing
    always_comb begin
        if (nan_a || nan_b) begin
            result = QNaN;
        end else if (inf_a && inf_b && (sa != sb)) begin
            result = QNaN;
        end else if (inf_a) begin
            result = a;
        end else if (inf_b) begin
            result = b;
        end else if (zero_a && zero_b) begin
            // Only -0 + -0 keeps the negative sign
            result = {sa & sb, 31'd0};
        end else if (is_cancel) begin
            result = 32'h00000000;
        end else if (exp_r >= 10'sd255) begin
            result = {sl, 8'hFF, 23'd0};
        end else if (exp_r <= 10'sd0) begin
            result = {sl, 31'd0};
        end else begin
            result = {sl, exp_r[7:0], frac_r};
        end
    end

    // Next-state for output registers: out only loads on valid input
    always_comb begin
        valid_d = in_valid;
        out_d   = in_valid ? result : out_q;
    end

    // Output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q   <= 32'h00000000;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_fp32_adder.sv
// Directed self-checking bench for fp32_adder.
module tb_fp32_adder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] out;
    logic        out_valid;

    int compared;
    int mismatched;

    fp32_adder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out       (out),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one operand pair, then advance to just after the capturing edge
    task automatic apply(input logic [31:0] va, input logic [31:0] vb, input logic v);
        a        = va;
        b        = vb;
        in_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        apply(32'h3F800000, 32'h3F800000, 1'b1);
        compared++;
        if (out !== 32'h00000000) begin
            mismatched++;
            $display("FAIL reset_out: got %h want %h", out, 32'h00000000);
        end
        compared++;
        if (out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_valid: got %b want %b", out_valid, 1'b0);
        end
        rst = 1'b0;
        apply(32'h3F800000, 32'h3F800000, 1'b1);
        compared++;
        if (out !== 32'h40000000) begin
            mismatched++;
            $display("FAIL first_sum: got %h want %h", out, 32'h40000000);
        end
        compared++;
        if (out_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL first_valid: got %b want %b", out_valid, 1'b1);
        end
    endtask

    task automatic test_arith();
        logic [31:0] va [6];
        logic [31:0] vb [6];
        logic [31:0] ve [6];
        // alignment + carry, mixed signs, cancellation, large shift, underflow, swap order
        va[0] = 32'h41360001; vb[0] = 32'h40B2041B; ve[0] = 32'h41878107;
        va[1] = 32'h40400000; vb[1] = 32'hBF800000; ve[1] = 32'h40000000;
        va[2] = 32'h40D00000; vb[2] = 32'hC0D00000; ve[2] = 32'h00000000;
        va[3] = 32'h3F800000; vb[3] = 32'h00800000; ve[3] = 32'h3F800000;
        va[4] = 32'h00800000; vb[4] = 32'h80C00000; ve[4] = 32'h80000000;
        va[5] = 32'hBF800000; vb[5] = 32'h40400000; ve[5] = 32'h40000000;
        for (int i = 0; i < 6; i++) begin
            apply(va[i], vb[i], 1'b1);
            compared++;
            if (out !== ve[i]) begin
                mismatched++;
                $display("FAIL arith[%0d] %h+%h: got %h want %h", i, va[i], vb[i], out, ve[i]);
            end
        end
    endtask

    task automatic test_rounding();
        logic [31:0] exp_v;
`ifdef FP_ADD_RNE_EN
        exp_v = 32'h3F800001;
`else
        exp_v = 32'h3F800000;
`endif
        apply(32'h3F800000, 32'h33C00000, 1'b1);
        compared++;
        if (out !== exp_v) begin
            mismatched++;
            $display("FAIL rounding: got %h want %h", out, exp_v);
        end
    endtask

    task automatic test_specials();
        logic [31:0] va [9];
        logic [31:0] vb [9];
        logic [31:0] ve [9];
        va[0] = 32'h7F800000; vb[0] = 32'hFF800000; ve[0] = 32'h7FC00000;
        va[1] = 32'h7F7FFFFF; vb[1] = 32'h7F7FFFFF; ve[1] = 32'h7F800000;
        va[2] = 32'h00400000; vb[2] = 32'h00000000; ve[2] = 32'h00000000;
        va[3] = 32'h7F800001; vb[3] = 32'h3F800000; ve[3] = 32'h7FC00000;
        va[4] = 32'h3F800000; vb[4] = 32'hFF800000; ve[4] = 32'hFF800000;
        va[5] = 32'hFF800000; vb[5] = 32'hFF800000; ve[5] = 32'hFF800000;
        va[6] = 32'h80000000; vb[6] = 32'h80000000; ve[6] = 32'h80000000;
        va[7] = 32'h80000000; vb[7] = 32'h00000000; ve[7] = 32'h00000000;
        va[8] = 32'hFF7FFFFF; vb[8] = 32'hFF7FFFFF; ve[8] = 32'hFF800000;
        for (int i = 0; i < 9; i++) begin
            apply(va[i], vb[i], 1'b1);
            compared++;
            if (out !== ve[i]) begin
                mismatched++;
                $display("FAIL special[%0d] %h+%h: got %h want %h", i, va[i], vb[i], out, ve[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] va [4];
        logic [31:0] vb [4];
        logic [31:0] ve [4];
        va[0] = 32'h3F800000; vb[0] = 32'h40000000; ve[0] = 32'h40400000; // 1+2=3
        va[1] = 32'h40800000; vb[1] = 32'hC0000000; ve[1] = 32'h40000000; // 4-2=2
        va[2] = 32'h3F000000; vb[2] = 32'h3F000000; ve[2] = 32'h3F800000; // .5+.5=1
        va[3] = 32'hC1200000; vb[3] = 32'h40A00000; ve[3] = 32'hC0A00000; // -10+5=-5
        for (int i = 0; i < 4; i++) begin
            apply(va[i], vb[i], 1'b1);
            compared++;
            if (out !== ve[i] || out_valid !== 1'b1) begin
                mismatched++;
                $display("FAIL b2b[%0d]: got %h/%b want %h/1", i, out, out_valid, ve[i]);
            end
        end
        // Idle cycles with changing operands: out holds, out_valid drops
        for (int i = 0; i < 2; i++) begin
            apply(32'h3F800000 + 32'(i), 32'h3F800000, 1'b0);
            compared++;
            if (out !== 32'hC0A00000 || out_valid !== 1'b0) begin
                mismatched++;
                $display("FAIL hold[%0d]: got %h/%b want %h/0", i, out, out_valid, 32'hC0A00000);
            end
        end
        apply(32'h40000000, 32'h40000000, 1'b1);
        compared++;
        if (out !== 32'h40800000 || out_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL resume: got %h/%b want %h/1", out, out_valid, 32'h40800000);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        a          = 32'h0;
        b          = 32'h0;
        @(negedge clk);
        test_reset();
        test_arith();
        test_rounding();
        test_specials();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
